// File: rtl/f_sub_seq.sv
// Multi-cycle single-precision subtractor (or adder when OP_SUB=0) on the packed float register format.
// Each normalization step moves the mantissa one bit, so the handshake absorbs the variable latency.
module f_sub_seq #(
    parameter bit OP_SUB       = 1'b1,
    parameter bit FLUSH_DENORM = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [63:0] read_f_data1,
    input  logic [63:0] read_f_data2,
    output logic        busy,
    output logic        done,
    output logic [63:0] alu_float_result
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ALIGN,
        S_ADDSUB,
        S_NORM,
        S_DONE
    } state_t;

    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    state_t      r_state, w_next;
    logic [31:0] r_a, r_b;
    logic        r_sign, r_eff_sub;
    logic [7:0]  r_exp;
    logic [23:0] r_mant_a, r_mant_b;
    logic [24:0] r_sum;
    logic [63:0] r_result;

    logic        w_sign_a, w_sign_b, w_a_big, w_special;
    logic [7:0]  w_exp_big, w_exp_small, w_diff;
    logic [23:0] w_mant_big, w_mant_small;
    logic [22:0] w_frac_big, w_frac_small;
    logic        w_norm_exit;
    logic [31:0] w_packed;
    logic        w_unused;

    // Only the upper single-precision word carries an operand.
    assign w_unused = ^{read_f_data1[31:0], read_f_data2[31:0]};

    // Unpack and order the latched operands; b's sign is flipped for subtraction.
    assign w_sign_a     = r_a[31];
    assign w_sign_b     = r_b[31] ^ OP_SUB;
    assign w_a_big      = (r_a[30:0] >= r_b[30:0]);
    assign w_exp_big    = w_a_big ? r_a[30:23] : r_b[30:23];
    assign w_exp_small  = w_a_big ? r_b[30:23] : r_a[30:23];
    assign w_frac_big   = w_a_big ? r_a[22:0]  : r_b[22:0];
    assign w_frac_small = w_a_big ? r_b[22:0]  : r_a[22:0];
    assign w_mant_big   = (w_exp_big == 8'd0 && FLUSH_DENORM) ? 24'd0 : {(w_exp_big != 8'd0), w_frac_big};
    assign w_mant_small = (w_exp_small == 8'd0 && FLUSH_DENORM) ? 24'd0 : {(w_exp_small != 8'd0), w_frac_small};
    assign w_diff       = w_exp_big - w_exp_small;
    assign w_special    = (r_a[30:23] == 8'hFF) || (r_b[30:23] == 8'hFF);

    assign w_norm_exit  = (r_sum == 25'd0) || (r_exp == 8'd0) || (r_sum[24:23] == 2'b01);

    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
        w_packed = {r_sign, r_exp, r_sum[22:0]};
        if (r_sum == 25'd0 || r_exp == 8'd0) begin
            w_packed = 32'h0000_0000;
        end else if (r_exp == 8'hFF) begin
            w_packed = {r_sign, 8'hFF, 23'd0};
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:   if (start) w_next = S_ALIGN;
            S_ALIGN:  w_next = w_special ? S_DONE : S_ADDSUB;
            S_ADDSUB: w_next = S_NORM;
            S_NORM:   if (w_norm_exit) w_next = S_DONE;
            S_DONE:   w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_a       <= '0;
            r_b       <= '0;
            r_sign    <= 1'b0;
            r_eff_sub <= 1'b0;
            r_exp     <= '0;
            r_mant_a  <= '0;
            r_mant_b  <= '0;
            r_sum     <= '0;
            r_result  <= '0;
        end else begin
            r_state <= w_next;
            unique case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_a <= read_f_data1[63:32];
                        r_b <= read_f_data2[63:32];
                    end
                end
                S_ALIGN: begin
                    if (w_special) begin
                        r_result <= {QNAN, 32'h0};
                    end else begin
                        r_sign    <= w_a_big ? w_sign_a : w_sign_b;
                        r_eff_sub <= w_sign_a ^ w_sign_b;
                        r_exp     <= w_exp_big;
                        r_mant_a  <= w_mant_big;
                        r_mant_b  <= (w_diff >= 8'd24) ? 24'd0 : (w_mant_small >> w_diff);
                    end
                end
                S_ADDSUB: begin
                    r_sum <= r_eff_sub ? ({1'b0, r_mant_a} - {1'b0, r_mant_b})
                                       : ({1'b0, r_mant_a} + {1'b0, r_mant_b});
                end
                S_NORM: begin
                    if (w_norm_exit) begin
                        r_result <= {w_packed, 32'h0};
                    end else if (r_sum[24]) begin
                        r_sum <= r_sum >> 1;
                        r_exp <= r_exp + 8'd1;
                    end else begin
                        r_sum <= r_sum << 1;
                        r_exp <= r_exp - 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy             = (r_state != S_IDLE);
    assign done             = (r_state == S_DONE);
    assign alu_float_result = r_result;

endmodule
